// File: rtl/stepper_driver.sv
// Single-motor stepper sequencer: walks PhysicalPosition one 45-degree step at a
// time toward DesiredPosition by the shorter way round, with a settle gap after every pulse.
module stepper_driver #(
  parameter int                     State_width  = 3,
  parameter int                     SettleCycles = 3,
  parameter logic [State_width-1:0] HomePosition = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Enable,
  input  logic [State_width-1:0] DesiredPosition,
  output logic [State_width-1:0] PhysicalPosition,
  output logic                   StepCW,
  output logic                   StepCCW,
  output logic                   Busy,
  output logic                   AtTarget,
  output logic [7:0]             StepCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STEP   = 2'b01,
    SETTLE = 2'b10
  } state_t;

  localparam logic [3:0]             SETTLE_LOAD = 4'(SettleCycles);
  localparam logic [State_width-1:0] POS_ONE     = 1;
  localparam logic [State_width-1:0] HALF_TURN   = POS_ONE << (State_width - 1);

  state_t                 state_q, state_d;
  logic                   dir_cw_q, dir_cw_d;
  logic [State_width-1:0] phys_q, phys_d;
  logic [7:0]             count_q, count_d;
  logic [3:0]             settle_q, settle_d;
  logic [State_width-1:0] diff;

  // Modular distance to target; half a turn or less is reached fastest clockwise.
  assign diff = DesiredPosition - phys_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      dir_cw_q <= 1'b1;
      phys_q   <= HomePosition;
      count_q  <= 8'd0;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      dir_cw_q <= dir_cw_d;
      phys_q   <= phys_d;
      count_q  <= count_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_cw_d = dir_cw_q;
    phys_d   = phys_q;
    count_d  = count_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (Enable && (diff != '0)) begin
          dir_cw_d = (diff <= HALF_TURN);
          state_d  = STEP;
        end
      end
      STEP: begin
        phys_d   = dir_cw_q ? (phys_q + POS_ONE) : (phys_q - POS_ONE);
        count_d  = count_q + 8'd1;
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 4'd1;
        // A zero load would otherwise wrap to 15; treat it as a single settle cycle.
        if (settle_q <= 4'd1) begin
          settle_d = 4'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PhysicalPosition = phys_q;
  assign StepCount        = count_q;
  assign StepCW           = (state_q == STEP) &&  dir_cw_q;
  assign StepCCW          = (state_q == STEP) && !dir_cw_q;
  assign Busy             = (state_q != IDLE);
  assign AtTarget         = (state_q == IDLE) && (phys_q == DesiredPosition);

endmodule

// File: tb/tb_stepper_driver.sv
// Scoreboard bench for stepper_driver: stimulus queues the pulses it expects,
// a negedge monitor pops and checks each pulse as the DUT emits it.
module tb_stepper_driver;

  logic       clk;
  logic       reset;
  logic       Enable;
  logic [2:0] DesiredPosition;
  logic [2:0] PhysicalPosition;
  logic       StepCW;
  logic       StepCCW;
  logic       Busy;
  logic       AtTarget;
  logic [7:0] StepCount;

  stepper_driver #(
    .State_width (3),
    .SettleCycles(3),
    .HomePosition(3'b000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Enable          (Enable),
    .DesiredPosition (DesiredPosition),
    .PhysicalPosition(PhysicalPosition),
    .StepCW          (StepCW),
    .StepCCW         (StepCCW),
    .Busy            (Busy),
    .AtTarget        (AtTarget),
    .StepCount       (StepCount)
  );

  typedef struct {
    logic       cw;
    logic [2:0] phys;
    logic [7:0] cnt;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   last_pulse_cyc = 0;
  bit   mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic cw, input logic [2:0] phys, input logic [7:0] cnt, input int gap);
    exp_t e;
    e.cw = cw; e.phys = phys; e.cnt = cnt; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && (StepCW || StepCCW)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got cw=%0b ccw=%0b phys=%0h expected no pulse",
                 StepCW, StepCCW, PhysicalPosition);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_dir", {30'd0, StepCW, StepCCW}, {30'd0, e.cw, ~e.cw});
        chk("pulse_phys", {29'd0, PhysicalPosition}, {29'd0, e.phys});
        chk("pulse_count", {24'd0, StepCount}, {24'd0, e.cnt});
        if (e.gap != 0) chk("pulse_gap", cyc - last_pulse_cyc, e.gap);
        $display("pulse cyc=%0d cw=%0b ccw=%0b phys=%0h count=%0d", cyc, StepCW, StepCCW,
                 PhysicalPosition, StepCount);
      end
      last_pulse_cyc = cyc;
    end
  end

  task automatic do_reset();
    Enable = 1'b0;
    reset  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_target(input string name, input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(AtTarget && !Busy) && n < maxc);
    if (!(AtTarget && !Busy)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no AtTarget after %0d cycles expected AtTarget", name, maxc);
    end
  endtask

  task automatic wait_pulse(input string name, input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(StepCW || StepCCW) && n < maxc);
    if (!(StepCW || StepCCW)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pulse after %0d cycles expected a pulse", name, maxc);
    end
  endtask

  initial begin
    reset = 1'b0;
    Enable = 1'b0;
    DesiredPosition = 3'b011;

    // Reset held two cycles with Desired=011
    repeat (2) @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    chk("rst_phys", {29'd0, PhysicalPosition}, 32'h0);
    chk("rst_busy", {31'd0, Busy}, 32'h0);
    chk("rst_count", {24'd0, StepCount}, 32'h0);
    chk("rst_attarget", {31'd0, AtTarget}, 32'h0);
    chk("rst_pulses", {30'd0, StepCW, StepCCW}, 32'h0);
    $display("txn reset: phys=%0h busy=%0b count=%0d attarget=%0b", PhysicalPosition, Busy,
             StepCount, AtTarget);

    // Desired equals home: no pulse, AtTarget high
    @(posedge clk);
    #1 reset = 1'b1; DesiredPosition = 3'b000; Enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("eq_attarget", {31'd0, AtTarget}, 32'h1);
    chk("eq_count", {24'd0, StepCount}, 32'h0);
    $display("txn equal: attarget=%0b count=%0d", AtTarget, StepCount);

    // Two CW steps 000 -> 010
    push(1'b1, 3'b000, 8'd0, 0);
    push(1'b1, 3'b001, 8'd1, 5);
    @(posedge clk); #1 DesiredPosition = 3'b010;
    wait_target("cw2", 40);
    chk("cw2_phys", {29'd0, PhysicalPosition}, 32'h2);
    chk("cw2_count", {24'd0, StepCount}, 32'h2);
    chk("cw2_busy", {31'd0, Busy}, 32'h0);
    $display("txn cw2: phys=%0h count=%0d", PhysicalPosition, StepCount);

    // Two CCW steps 000 -> 110
    do_reset();
    push(1'b0, 3'b000, 8'd0, 0);
    push(1'b0, 3'b111, 8'd1, 5);
    DesiredPosition = 3'b110; Enable = 1'b1;
    wait_target("ccw2", 40);
    chk("ccw2_phys", {29'd0, PhysicalPosition}, 32'h6);
    chk("ccw2_count", {24'd0, StepCount}, 32'h2);
    $display("txn ccw2: phys=%0h count=%0d", PhysicalPosition, StepCount);

    // Half-turn tie resolves CW
    do_reset();
    push(1'b1, 3'b000, 8'd0, 0);
    push(1'b1, 3'b001, 8'd1, 5);
    push(1'b1, 3'b010, 8'd2, 5);
    push(1'b1, 3'b011, 8'd3, 5);
    DesiredPosition = 3'b100; Enable = 1'b1;
    wait_target("tie", 60);
    chk("tie_phys", {29'd0, PhysicalPosition}, 32'h4);
    chk("tie_count", {24'd0, StepCount}, 32'h4);
    $display("txn tie: phys=%0h count=%0d", PhysicalPosition, StepCount);

    // Wrap: reach 111, go CW to 001, retarget to 111 during first SETTLE
    do_reset();
    push(1'b0, 3'b000, 8'd0, 0);
    DesiredPosition = 3'b111; Enable = 1'b1;
    wait_target("wrap_pre", 30);
    chk("wrap_pre_phys", {29'd0, PhysicalPosition}, 32'h7);
    push(1'b1, 3'b111, 8'd1, 0);
    push(1'b0, 3'b000, 8'd2, 5);
    @(posedge clk); #1 DesiredPosition = 3'b001;
    wait_pulse("wrap_cw", 20);
    @(posedge clk); #1 DesiredPosition = 3'b111;
    @(negedge clk);
    chk("wrap_settle_busy", {31'd0, Busy}, 32'h1);
    chk("wrap_settle_phys", {29'd0, PhysicalPosition}, 32'h0);
    wait_target("wrap", 40);
    chk("wrap_phys", {29'd0, PhysicalPosition}, 32'h7);
    chk("wrap_count", {24'd0, StepCount}, 32'h3);
    $display("txn wrap: phys=%0h count=%0d", PhysicalPosition, StepCount);

    // Reset asserted during STEP wins
    do_reset();
    push(1'b1, 3'b000, 8'd0, 0);
    DesiredPosition = 3'b010; Enable = 1'b1;
    wait_pulse("rst_step", 20);
    reset = 1'b0;
    @(negedge clk);
    chk("rststep_phys", {29'd0, PhysicalPosition}, 32'h0);
    chk("rststep_count", {24'd0, StepCount}, 32'h0);
    chk("rststep_pulse", {30'd0, StepCW, StepCCW}, 32'h0);
    chk("rststep_busy", {31'd0, Busy}, 32'h0);
    $display("txn rst_step: phys=%0h count=%0d busy=%0b", PhysicalPosition, StepCount, Busy);

    // Enable dropped in SETTLE: step completes, no more pulses
    push(1'b1, 3'b000, 8'd0, 0);
    reset = 1'b1;
    wait_pulse("en_drop", 20);
    @(posedge clk); #1 Enable = 1'b0;
    repeat (20) @(negedge clk);
    chk("endrop_phys", {29'd0, PhysicalPosition}, 32'h1);
    chk("endrop_count", {24'd0, StepCount}, 32'h1);
    chk("endrop_busy", {31'd0, Busy}, 32'h0);
    chk("endrop_attarget", {31'd0, AtTarget}, 32'h0);
    $display("txn en_drop: phys=%0h count=%0d busy=%0b", PhysicalPosition, StepCount, Busy);

    chk("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_driver.md
STEPPER_DRIVER -- requirements
Module: stepper_driver

Interface
- REQ-001: The parameters SHALL be as follows, one per line (name, default, meaning):
  - State_width, 3, position width; 2^State_width positions in 45-degree steps.
  - SettleCycles, 3, idle cycles after each step pulse; legal range 1..15.
  - HomePosition, 3'b000, PhysicalPosition value after reset.
- REQ-002: The ports SHALL be as follows, one per line (name, direction, width, meaning):
  - clk, input, 1, single clock; all logic on posedge.
  - reset, input, 1, synchronous, active-low.
  - Enable, input, 1, permits new steps.
  - DesiredPosition, input, State_width, target angle from the angle controller.
  - PhysicalPosition, output, State_width, registered current motor angle.
  - StepCW, output, 1, one-cycle step pulse, clockwise.
  - StepCCW, output, 1, one-cycle step pulse, counter-clockwise.
  - Busy, output, 1, high when state is not IDLE.
  - AtTarget, output, 1, high when state is IDLE and PhysicalPosition == DesiredPosition.
  - StepCount, output, 8, registered count of step pulses issued; wraps 255->0.

Function
- REQ-003: The FSM SHALL have three states, IDLE, STEP and SETTLE, and SHALL leave no unreachable encoding without a path to IDLE.
- REQ-004: In IDLE, when Enable=1 and DesiredPosition != PhysicalPosition, the FSM SHALL register a direction and enter STEP on the next edge; otherwise it SHALL remain in IDLE.
- REQ-005: Direction SHALL derive from Diff = (DesiredPosition - PhysicalPosition) mod 2^State_width: CW for Diff in 1..4, CCW for Diff in 5..7.
- REQ-006: A tie at Diff=4 SHALL resolve CW.
- REQ-007: StepCW/StepCCW SHALL be Moore outputs, high for exactly the one STEP cycle in the registered direction.
- REQ-008: StepCW and StepCCW SHALL never be high together.
- REQ-009: On the edge leaving STEP, PhysicalPosition SHALL update by +1 (CW) or -1 (CCW) modulo 2^State_width (111+1=000, 000-1=111), and StepCount SHALL increment.
- REQ-010: SETTLE SHALL last exactly SettleCycles cycles, counted by a 4-bit counter loaded on STEP exit, then return to IDLE.
- REQ-011: Minimum spacing between consecutive step pulses SHALL be SettleCycles+2 cycles.
- REQ-012: DesiredPosition SHALL be sampled only in IDLE; a change during STEP/SETTLE SHALL take effect at the next IDLE evaluation, and the in-flight step SHALL complete.
- REQ-013: Deassertion of Enable during STEP/SETTLE SHALL NOT abort the step; the FSM SHALL return to IDLE and hold there.
- REQ-014: Busy and AtTarget SHALL be decoded from registered state and positions only.
- REQ-015: A DesiredPosition equal to PhysicalPosition in IDLE SHALL produce no pulse, with AtTarget=1.

Reset
- REQ-016: When reset=0 at a clk edge, state SHALL become IDLE, PhysicalPosition SHALL become HomePosition, StepCount and the settle counter SHALL become 0, and the stored direction SHALL become CW.
- REQ-017: Reset SHALL take priority over every other input, including mid-STEP and mid-SETTLE.
- REQ-018: In the cycle after a reset edge, StepCW=StepCCW=0 and Busy=0; AtTarget SHALL equal (DesiredPosition == HomePosition).
- REQ-019: No asynchronous path from reset SHALL exist.

Verification
- REQ-020: reset=0 for 2 cycles with Desired=011 -> PhysicalPosition=000, Busy=0, no pulses, StepCount=0, AtTarget=0.
- REQ-021: Phys=000, Desired=010, Enable=1, SettleCycles=3 -> StepCW pulses 5 cycles apart, Phys 001 then 010, StepCount=2, AtTarget=1, Busy=0.
- REQ-022: Phys=000, Desired=110 -> two StepCCW pulses, Phys 111 then 110, no StepCW.
- REQ-023: Phys=000, Desired=100 (tie) -> four StepCW pulses, Phys 001, 010, 011, 100.
- REQ-024: Phys=111, Desired=001 -> CW wrap, Phys 000 then 001; Desired changed to 111 during first SETTLE -> the next step is CCW back to 111.
- REQ-025: reset=0 asserted in the STEP cycle -> next cycle Phys=000, StepCount unchanged at 0, no pulse; Enable=0 mid-SETTLE -> returns to IDLE, no further pulses.
